// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths, register-zero constant, source tags and FIFO entry type for the GRF write-side arbiter.
package grf_wb_arbiter_pkg;

  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;
  localparam int GRF_REGS   = 32;
  localparam logic [GRF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_PW = 1'b0,
    SRC_MD = 1'b1
  } src_e;

  typedef struct packed {
    logic [GRF_ADDR_W-1:0] addr;
    logic [GRF_DATA_W-1:0] data;
    logic [GRF_DATA_W-1:0] pc4;
  } wb_entry_t;

  function automatic logic [GRF_REGS-1:0] reg_onehot(input logic [GRF_ADDR_W-1:0] a);
    reg_onehot = 32'd1 << a;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// DEPTH-entry {addr, data, pc4} FIFO holding mult/div results, with a per-slot valid/address view.
module grf_wb_arbiter_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             push,
  input  logic                             pop,
  input  wb_entry_t                        din,
  output wb_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH*GRF_ADDR_W-1:0]      entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t               mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [DEPTH-1:0]        valid_r;
  logic                    push_s;
  logic                    pop_s;

  assign full        = (count_r == CNT_W'(DEPTH));
  assign empty       = (count_r == {CNT_W{1'b0}});
  assign count       = count_r;
  assign entry_valid = valid_r;
  assign head        = mem_r[rd_ptr_r];
  assign push_s      = push & ~full;
  assign pop_s       = pop & ~empty;

  // Flatten stored destination addresses for the pending decode.
  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i*GRF_ADDR_W +: GRF_ADDR_W] = mem_r[i].addr;
    end
  end

  // Storage, pointers, occupancy and slot-valid bits; pointers wrap naturally.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r]   <= din;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Merges pipeline WB and buffered mult/div results onto the single GRF write port.
// Optional macro GRF_WB_TRACE_EN prints a line for every GRF write with its source tag.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  pw_valid,
  input  logic [GRF_ADDR_W-1:0] pw_addr,
  input  logic [GRF_DATA_W-1:0] pw_data,
  input  logic [GRF_DATA_W-1:0] pw_pc4,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [GRF_ADDR_W-1:0] md_addr,
  input  logic [GRF_DATA_W-1:0] md_data,
  input  logic [GRF_DATA_W-1:0] md_pc4,
  output logic                  grf_we,
  output logic [GRF_ADDR_W-1:0] grf_a3,
  output logic [GRF_DATA_W-1:0] grf_wd,
  output logic [GRF_DATA_W-1:0] grf_pc4,
  output logic [GRF_REGS-1:0]   pending,
  output logic                  stall_req
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

  wb_entry_t                     md_entry_s;
  wb_entry_t                     head_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic [$clog2(DEPTH):0]        fifo_count_s;
  logic [DEPTH-1:0]              entry_valid_s;
  logic [DEPTH*GRF_ADDR_W-1:0]   entry_addr_s;
  logic                          push_s;
  logic                          pop_s;
  logic [GRF_REGS-1:0]           pending_s;
  logic [STV_W-1:0]              starve_next_s;
  logic [STV_W-1:0]              starve_r;
  logic                          stall_req_r;
  logic                          grf_we_r;
  logic [GRF_ADDR_W-1:0]         grf_a3_r;
  logic [GRF_DATA_W-1:0]         grf_wd_r;
  logic [GRF_DATA_W-1:0]         grf_pc4_r;

  // $0 results are acknowledged but never buffered.
  assign md_entry_s = '{addr: md_addr, data: md_data, pc4: md_pc4};
  assign push_s     = md_valid & ~fifo_full_s & (md_addr != REG_ZERO);
  assign pop_s      = ~pw_valid & ~fifo_empty_s;

  grf_wb_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .push        (push_s),
    .pop         (pop_s),
    .din         (md_entry_s),
    .head        (head_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .count       (fifo_count_s),
    .entry_valid (entry_valid_s),
    .entry_addr  (entry_addr_s)
  );

  // Registers with buffered writes outstanding.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid_s[i]) begin
        pending_s = pending_s | reg_onehot(entry_addr_s[i*GRF_ADDR_W +: GRF_ADDR_W]);
      end else begin
        pending_s = pending_s;
      end
    end
    pending_s[0] = 1'b0;
  end

  // Next starvation count: reset by a drain or an empty FIFO, saturating otherwise.
  always_comb begin
    starve_next_s = starve_r;
    if (pop_s || (fifo_count_s == '0)) begin
      starve_next_s = {STV_W{1'b0}};
    end else if (pw_valid && (starve_r != STARVE_TOP)) begin
      starve_next_s = starve_r + STV_W'(1);
    end else begin
      starve_next_s = starve_r;
    end
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      starve_r    <= {STV_W{1'b0}};
      stall_req_r <= 1'b0;
    end else begin
      starve_r    <= starve_next_s;
      stall_req_r <= (starve_next_s == STARVE_TOP);
    end
  end

  // Issue selection: pipeline first, then FIFO head; idle cycles hold the data fields.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      grf_we_r  <= 1'b0;
      grf_a3_r  <= 5'd0;
      grf_wd_r  <= 32'd0;
      grf_pc4_r <= 32'd0;
    end else if (pw_valid) begin
      grf_we_r  <= 1'b1;
      grf_a3_r  <= pw_addr;
      grf_wd_r  <= pw_data;
      grf_pc4_r <= pw_pc4;
    end else if (!fifo_empty_s) begin
      grf_we_r  <= 1'b1;
      grf_a3_r  <= head_s.addr;
      grf_wd_r  <= head_s.data;
      grf_pc4_r <= head_s.pc4;
    end else begin
      grf_we_r  <= 1'b0;
    end
  end

`ifdef GRF_WB_TRACE_EN
  src_e src_r;

  // Source tag of the write currently on the GRF port.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      src_r <= SRC_PW;
    end else if (pw_valid) begin
      src_r <= SRC_PW;
    end else if (!fifo_empty_s) begin
      src_r <= SRC_MD;
    end else begin
      src_r <= src_r;
    end
  end

  // Write trace.
  always @(posedge Clk) begin
    if (grf_we_r) begin
      $display("%d@%h: $%d <= %h %0s", $time, grf_pc4_r - 32'd4, grf_a3_r, grf_wd_r,
               (src_r == SRC_MD) ? "MD" : "PW");
    end
  end
`endif

  assign grf_we    = grf_we_r;
  assign grf_a3    = grf_a3_r;
  assign grf_wd    = grf_wd_r;
  assign grf_pc4   = grf_pc4_r;
  assign stall_req = stall_req_r;
  assign md_ready  = ~fifo_full_s;
  assign pending   = pending_s;

endmodule
